// File: rtl/mask_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mask_decoder
// Purpose  : Registered code-to-mask decoder with valid/ready handshakes on
//            both sides. Modes: LEGACY (4-to-16 transcoder compatible),
//            ONEHOT, THERM (thermometer) and SCAN (autonomous one-hot sweep
//            of codes 0..k with a programmable idle dwell between beats).
// Ports    : clk, rst_n     - rising-edge clock, async active-low reset
//            flush          - synchronous abort back to IDLE
//            in_valid/in_ready, in_code, mode, dwell - request side
//            out_valid/out_ready, out_mask, out_code - beat side
//            busy           - high while a scan is in progress
// Revision : 1.0 - initial release
// ============================================================================
module mask_decoder #(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 2**IN_W,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_code,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_mask,
  output logic [IN_W-1:0]    out_code,
  output logic               busy
);

  localparam logic [1:0]      C_MODE_LEGACY = 2'b00;
  localparam logic [1:0]      C_MODE_ONEHOT = 2'b01;
  localparam logic [1:0]      C_MODE_THERM  = 2'b10;
  localparam logic [1:0]      C_MODE_SCAN   = 2'b11;
  localparam logic [IN_W-1:0] C_CODE_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SCAN_OUT   = 2'd1,
    S_SCAN_DWELL = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [IN_W-1:0]    r_last, w_last_next;
  logic [DWELL_W-1:0] r_dwell, w_dwell_next;
  logic [DWELL_W-1:0] r_cnt, w_cnt_next;
  logic               w_valid_next, w_busy_next;
  logic [OUT_W-1:0]   w_mask_next;
  logic [IN_W-1:0]    w_code_next;
  logic [IN_W-1:0]    w_code_inc;
  logic [OUT_W-1:0]   w_in_onehot;
  logic [OUT_W-1:0]   w_in_mask;
  logic               w_accept, w_handshake;

  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] k);
    onehot = OUT_W'(1) << k;
  endfunction

  // A new request fits only when IDLE and the output slot is free or draining
  // this cycle; gating with rst_n keeps in_ready low throughout reset.
  assign in_ready    = (r_state == S_IDLE) && (!out_valid || out_ready) && rst_n;
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = out_valid && out_ready;
  assign w_code_inc  = out_code + IN_W'(1);
  assign w_in_onehot = onehot(in_code);

  always_comb begin
    w_in_mask = w_in_onehot;
    case (mode)
      C_MODE_LEGACY: begin
        // Endpoints differ from one-hot for transcoder compatibility.
        if (in_code == '0)
          w_in_mask = '0;
        else if (in_code == C_CODE_MAX)
          w_in_mask = '1;
        else
          w_in_mask = w_in_onehot;
      end
      C_MODE_ONEHOT: w_in_mask = w_in_onehot;
      // (1<<k)-1 gives bits [k-1:0]; k=MAX naturally leaves the MSB clear.
      C_MODE_THERM:  w_in_mask = w_in_onehot - OUT_W'(1);
      default:       w_in_mask = w_in_onehot;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_dwell_next = r_dwell;
    w_cnt_next   = r_cnt;
    w_valid_next = out_valid;
    w_mask_next  = out_mask;
    w_code_next  = out_code;
    w_busy_next  = busy;

    if (flush) begin
      // Mask/code deliberately hold; any same-cycle accept is dropped.
      w_state_next = S_IDLE;
      w_valid_next = 1'b0;
      w_busy_next  = 1'b0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_valid_next = 1'b1;
            if (mode == C_MODE_SCAN) begin
              w_last_next  = in_code;
              w_dwell_next = dwell;
              w_mask_next  = OUT_W'(1);
              w_code_next  = '0;
              w_busy_next  = 1'b1;
              w_state_next = S_SCAN_OUT;
            end else begin
              w_mask_next = w_in_mask;
              w_code_next = in_code;
            end
          end else if (w_handshake) begin
            w_valid_next = 1'b0;
          end
        end

        S_SCAN_OUT: begin
          if (w_handshake) begin
            if (out_code == r_last) begin
              w_valid_next = 1'b0;
              w_busy_next  = 1'b0;
              w_state_next = S_IDLE;
            end else if (r_dwell == '0) begin
              w_code_next = w_code_inc;
              w_mask_next = onehot(w_code_inc);
            end else begin
              w_valid_next = 1'b0;
              w_cnt_next   = r_dwell;
              w_state_next = S_SCAN_DWELL;
            end
          end
        end

        S_SCAN_DWELL: begin
          // cnt is loaded non-zero, so the <=1 test fires at 1; it also
          // guarantees the down-counter can never wrap.
          if (r_cnt <= DWELL_W'(1)) begin
            w_valid_next = 1'b1;
            w_code_next  = w_code_inc;
            w_mask_next  = onehot(w_code_inc);
            w_cnt_next   = '0;
            w_state_next = S_SCAN_OUT;
          end else begin
            w_cnt_next = r_cnt - DWELL_W'(1);
          end
        end

        default: begin
          w_state_next = S_IDLE;
          w_valid_next = 1'b0;
          w_busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= '0;
      r_dwell   <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_code  <= '0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_last    <= w_last_next;
      r_dwell   <= w_dwell_next;
      r_cnt     <= w_cnt_next;
      out_valid <= w_valid_next;
      out_mask  <= w_mask_next;
      out_code  <= w_code_next;
      busy      <= w_busy_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/mask_decoder.md
# mask_decoder

Registered, parametrised code-to-mask decoder with valid/ready handshaking on both sides. It generalises the front-end 4-to-16 transcoder to any code width and adds selectable mask modes plus an autonomous scan mode. Scan mode steps a one-hot mask through codes 0..N with a programmable dwell between beats. It sits between the control/register interface and the channel-enable / trigger-select logic of the acquisition path.

## Interface
- `IN_W`, 4, code width in bits.
- `OUT_W`, 2**IN_W, mask width; must equal 2**IN_W.
- `DWELL_W`, 16, width of the dwell counter.

- `clk` in 1 — single clock, all logic rising-edge.
- `rst_n` in 1 — one clock; reset is asynchronous and active-low.
- `flush` in 1 — synchronous abort; priority over everything except reset.
- `in_valid` in 1 — input request.
- `in_ready` out 1 — block accepts request this cycle.
- `in_code` in IN_W — code k.
- `mode` in 2 — 00 LEGACY, 01 ONEHOT, 10 THERM, 11 SCAN; sampled at accept.
- `dwell` in DWELL_W — idle cycles between scan beats; sampled at accept.
- `out_valid` out 1 — output beat present.
- `out_ready` in 1 — downstream accepts beat.
- `out_mask` out OUT_W — decoded mask (registered).
- `out_code` out IN_W — code that produced `out_mask` (registered).
- `busy` out 1 — scan in progress.

## Operation
- Accept = `in_valid && in_ready`. Handshake = `out_valid && out_ready`.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready) && rst_n. It is 0 in SCAN_OUT and SCAN_DWELL.
- Mask functions, with MAX = 2**IN_W-1:
  - LEGACY: k=0 → 0; 1≤k<MAX → 1<<k; k=MAX → all ones.
  - ONEHOT: 1<<k for every k.
  - THERM: bits [k-1:0] set; k=0 → 0; k=MAX → OUT_W-1 ones, MSB clear.
- IDLE, modes 00/01/10:
  - Accept loads `out_mask`, `out_code`=k and `out_valid`=1.
  - A handshake with no accept clears `out_valid`; mask/code hold their last values.
  - An accept and a handshake in the same cycle replace the beat; the pipeline stays full.
- IDLE, SCAN accept:
  - Latch `last`=k and `dwell_q`=dwell.
  - Load `out_mask`=1, `out_code`=0, `out_valid`=1, `busy`=1; go to SCAN_OUT.
- SCAN_OUT, on handshake:
  - If `out_code == last`: `out_valid`=0, `busy`=0, go to IDLE.
  - Else if `dwell_q == 0`: `out_code`+1, `out_mask`=1<<(`out_code`+1), stay in SCAN_OUT (back-to-back beats).
  - Else: `out_valid`=0, `cnt`=`dwell_q`, go to SCAN_DWELL.
- SCAN_OUT without a handshake holds all outputs.
- SCAN_DWELL:
  - If `cnt == 1`: present next code (`out_valid`=1, code+1, one-hot mask), go to SCAN_OUT.
  - Else `cnt`-1. The counter never wraps.
- `flush`: next cycle `out_valid`=0, `busy`=0, state IDLE, `cnt`=0. Mask/code hold. Any same-cycle accept is discarded.
- Scan with k=0 emits a single beat (mask 1) and then returns to IDLE.

## Timing
- Reset values: `out_valid`=0, `out_mask`=0, `out_code`=0, `busy`=0, state IDLE, `cnt`=0, `in_ready`=0 while `rst_n` is low.
- Reset asserted mid-scan clears everything immediately (asynchronously); no beat completes.
- Latency: accept at cycle N → `out_valid` at N+1, for every mode including the first scan beat.
- Throughput: 1 beat/cycle in modes 00/01/10 when `out_ready` is held high.
- Scan: handshake at cycle T with dwell D>0 → `out_valid` low for cycles T+1..T+D, next beat at T+D+1.
- Scan with D=0: beats at consecutive cycles while `out_ready`=1.
- A scan of k with dwell D and `out_ready` always high lasts (k+1) + k·D cycles from N+1.
- `in_ready` rises one cycle after the final scan handshake (state returns to IDLE, `out_valid`=0).
- `out_valid`, once high, is never withdrawn without a handshake, except by `flush`. Mask and code stay stable while valid and not ready.

## Test plan
- Reset then LEGACY sweep k=0..15 at IN_W=4 with `out_ready`=1 → masks 0x0000, 0x0002 … 0x4000, 0xFFFF, each one cycle after accept, one per cycle.
- ONEHOT k=0 → 0x0001; THERM k=5 → 0x001F; THERM k=15 → 0x7FFF; THERM k=0 → 0x0000.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, mask/code stable, no beat lost or duplicated when `out_ready` returns.
- SCAN k=3, D=2, `out_ready`=1 → masks 0x1, 0x2, 0x4, 0x8 with exactly 2 invalid cycles between beats; `busy` high across the scan; `in_ready`=0 until the cycle after beat 3.
- SCAN k=7, D=0 → 8 consecutive beats; `out_ready` pulsed low mid-scan holds the current beat.
- `flush` in SCAN_DWELL during a k=15 scan, and separately `rst_n` low in SCAN_OUT → `out_valid`=0 and `busy`=0 on the next edge (immediately for reset); a subsequent ONEHOT k=2 yields 0x0004.
